// File: rtl/ping_burst_delay.sv
// Gates a square-wave carrier into periodic pinger bursts and emits four per-hydrophone copies, each delayed by its own latched cycle count.
// Define PING_JITTER_EN to lengthen every gap by an LFSR-driven 0..255 cycles.
module ping_burst_delay #(
   parameter int BURST_TICKS  = 48000,
   parameter int PERIOD_TICKS = 24000000,
   parameter int DELAY_W      = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic               carrier,
   input  logic [DELAY_W-1:0] delay0,
   input  logic [DELAY_W-1:0] delay1,
   input  logic [DELAY_W-1:0] delay2,
   input  logic [DELAY_W-1:0] delay3,
   output logic               ping,
   output logic               burst_active,
   output logic               burst_start,
   output logic [3:0]         hydro
);

   localparam int          DEPTH      = (2 ** DELAY_W) - 1;
   localparam logic [31:0] BURST_LAST = 32'(BURST_TICKS - 1);
   localparam logic [31:0] GAP_LAST   = 32'(PERIOD_TICKS - BURST_TICKS - 1);

   typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

   state_t             state;
   state_t             state_nxt;
   logic               entering;
   logic [31:0]        counter;
   logic [31:0]        gap_last;
   logic [DEPTH-1:0]   hist;
   logic [DELAY_W-1:0] dly [4];

`ifdef PING_JITTER_EN
   logic [15:0] lfsr;
   logic [15:0] lfsr_nxt;

   // Fibonacci taps 16,14,13,11; the gap uses the value stepped at the preceding burst start.
   assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign gap_last = GAP_LAST + {24'd0, lfsr[7:0]};

   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr <= 16'hACE1;
      end else if (entering) begin
         lfsr <= lfsr_nxt;
      end
   end
`else
   assign gap_last = GAP_LAST;
`endif

   always_comb begin
      state_nxt = state;
      entering  = 1'b0;
      case (state)
         IDLE:    if (enable) state_nxt = BURST;
         BURST:   if (counter == BURST_LAST) state_nxt = GAP;
         GAP:     if (counter == gap_last) state_nxt = BURST;
         default: state_nxt = IDLE;
      endcase
      if (!enable) begin
         state_nxt = IDLE;
      end
      entering = (state_nxt == BURST) && (state != BURST);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         counter      <= '0;
         ping         <= 1'b0;
         burst_active <= 1'b0;
         burst_start  <= 1'b0;
         hist         <= '0;
         for (int k = 0; k < 4; k++) begin
            dly[k] <= '0;
         end
      end else begin
         state        <= state_nxt;
         counter      <= (state_nxt != state) ? 32'd0 : counter + 32'd1;
         ping         <= carrier & (state_nxt == BURST);
         burst_active <= (state_nxt == BURST);
         burst_start  <= entering;
         // Keeps shifting in IDLE so an aborted burst still drains out of every channel.
         hist         <= {hist[DEPTH-2:0], ping};
         if (entering) begin
            dly[0] <= delay0;
            dly[1] <= delay1;
            dly[2] <= delay2;
            dly[3] <= delay3;
         end
      end
   end

   // hist[i] holds ping from i+1 cycles ago, so delay d selects hist[d-1].
   always_comb begin
      hydro = '0;
      for (int k = 0; k < 4; k++) begin
         hydro[k] = (dly[k] == '0) ? ping : hist[dly[k] - 1'b1];
      end
   end

endmodule

// File: tb/tb_ping_burst_delay.sv
// Directed bench for ping_burst_delay: per-cycle scoreboard against a behavioural model plus burst timing and delay checks.
module tb_ping_burst_delay;

   localparam int BT = 10;
   localparam int PT = 30;
   localparam int DW = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          enable;
   logic          carrier;
   logic [DW-1:0] delay0, delay1, delay2, delay3;
   logic          ping;
   logic          burst_active;
   logic          burst_start;
   logic [3:0]    hydro;

   int n_tot = 0;
   int n_bad = 0;

   ping_burst_delay #(.BURST_TICKS(BT), .PERIOD_TICKS(PT), .DELAY_W(DW)) dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .carrier      (carrier),
      .delay0       (delay0),
      .delay1       (delay1),
      .delay2       (delay2),
      .delay3       (delay3),
      .ping         (ping),
      .burst_active (burst_active),
      .burst_start  (burst_start),
      .hydro        (hydro)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic       p;
      logic       ba;
      logic       bs;
      logic [3:0] h;
   } exp_t;

   exp_t sb[$];

   // Behavioural model state; pings[] is the full ping history indexed by cycle.
   int            m_st  = 0;
   int            m_cnt = 0;
   logic          m_ping, m_ba, m_bs;
   logic [DW-1:0] m_del [4];
   logic          pings [0:8191];
   int            cyc     = 0;
   int            floor_c = 0;

   logic [4:0] prev_w = '0;
   logic       obs_bs = 1'b0;
   int         rise_c [5];
   int         fall_c [5];
   int         ba_run = 0;
   int         ba_len = 0;
   int         h3_cnt = 0;

`ifdef PING_JITTER_EN
   logic [15:0] m_lfsr;

   function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction
`endif

   task automatic model_edge();
      int   nst;
      int   gap_last;
      int   d;
      logic ent;
      exp_t e;
      cyc++;
      if (reset) begin
         m_st = 0; m_cnt = 0; m_ping = 1'b0; m_ba = 1'b0; m_bs = 1'b0;
         for (int k = 0; k < 4; k++) m_del[k] = '0;
`ifdef PING_JITTER_EN
         m_lfsr = 16'hACE1;
`endif
         floor_c = cyc;
      end else begin
         gap_last = PT - BT - 1;
`ifdef PING_JITTER_EN
         gap_last += int'(m_lfsr[7:0]);
`endif
         nst = m_st;
         if (!enable) nst = 0;
         else if (m_st == 0) nst = 1;
         else if (m_st == 1 && m_cnt == BT - 1) nst = 2;
         else if (m_st == 2 && m_cnt == gap_last) nst = 1;
         ent    = (nst == 1) && (m_st != 1);
         m_bs   = ent;
         m_ba   = (nst == 1);
         m_ping = carrier && (nst == 1);
         if (ent) begin
            m_del[0] = delay0; m_del[1] = delay1; m_del[2] = delay2; m_del[3] = delay3;
`ifdef PING_JITTER_EN
            m_lfsr = lfsr_adv(m_lfsr);
`endif
         end
         m_cnt = (nst != m_st) ? 0 : m_cnt + 1;
         m_st  = nst;
      end
      pings[cyc] = m_ping;
      e.p  = m_ping;
      e.ba = m_ba;
      e.bs = m_bs;
      for (int k = 0; k < 4; k++) begin
         d = m_del[k];
         e.h[k] = (cyc - d < floor_c) ? 1'b0 : pings[cyc - d];
      end
      sb.push_back(e);
   endtask

   task automatic track(input exp_t o);
      logic [4:0] w;
      w = {o.p, o.h};
      for (int i = 0; i < 5; i++) begin
         if (w[i] && !prev_w[i]) rise_c[i] = cyc;
         if (!w[i] && prev_w[i]) fall_c[i] = cyc;
      end
      prev_w = w;
      obs_bs = o.bs;
      if (o.ba) begin
         ba_run++;
      end else begin
         if (ba_run > 0) ba_len = ba_run;
         ba_run = 0;
      end
      if (o.h[3]) h3_cnt++;
   endtask

   task automatic step();
      exp_t e;
      exp_t o;
      model_edge();
      @(posedge clock);
      #1;
      e = sb.pop_front();
      o = {ping, burst_active, burst_start, hydro};
      n_tot++;
      assert (o === e) else begin
         n_bad++;
         $error("FAIL cyc%0d observed=%b expected=%b", cyc, o, e);
      end
      track(o);
   endtask

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_tot++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic wait_bs(input int budget);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!obs_bs && n < budget);
      chk("wait_burst_start", int'(obs_bs), 1);
   endtask

   initial begin
      int t0;
      int t1;
      int exp_period;
      int dv [4];
      dv = '{0, 3, 7, 15};
      for (int i = 0; i < 5; i++) begin
         rise_c[i] = 0;
         fall_c[i] = 0;
      end

      reset = 1'b1; enable = 1'b0; carrier = 1'b1;
      delay0 = '0; delay1 = '0; delay2 = '0; delay3 = '0;
      step();
      step();
      chk("reset_ping", int'(ping), 0);
      chk("reset_active", int'(burst_active), 0);
      chk("reset_hydro", int'(hydro), 0);

      // Burst length and burst-start period
      reset = 1'b0; enable = 1'b1;
      wait_bs(5);
      t0 = cyc;
      repeat (12) step();
      chk("burst_len", ba_len, BT);
      wait_bs(400);
      t1 = cyc;
      exp_period = PT;
`ifdef PING_JITTER_EN
      exp_period += int'(lfsr_adv(16'hACE1) & 16'h00FF);
`endif
      chk("period", t1 - t0, exp_period);

      // Carrier toggling every two cycles with zero delays
      for (int i = 0; i < 30; i++) begin
         carrier = ((i / 2) % 2 == 0);
         step();
      end

      // Per-channel offsets and pulse widths
      carrier = 1'b1;
      delay0 = 4'd0; delay1 = 4'd3; delay2 = 4'd7; delay3 = 4'd15;
      wait_bs(400);
      repeat (26) step();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("offset_h%0d", k), rise_c[k] - rise_c[4], dv[k]);
         chk($sformatf("width_h%0d", k), fall_c[k] - rise_c[k], BT);
      end

      // Delay change mid-burst takes effect only at the next burst start
      wait_bs(400);
      repeat (4) step();
      delay1 = 4'd5;
      repeat (22) step();
      chk("dchg_current", rise_c[1] - rise_c[4], 3);
      wait_bs(400);
      repeat (26) step();
      chk("dchg_next", rise_c[1] - rise_c[4], 5);

      // Abort after four burst cycles; the stub still drains through channel 3
      wait_bs(400);
      h3_cnt = 0;
      repeat (3) step();
      enable = 1'b0;
      step();
      chk("abort_ping", int'(ping), 0);
      chk("abort_active", int'(burst_active), 0);
      repeat (25) step();
      chk("abort_stub", h3_cnt, 4);

      // Reset in the gap clears the pending tail immediately
      enable = 1'b1;
      wait_bs(5);
      repeat (14) step();
      reset = 1'b1;
      step();
      chk("rstgap_ping", int'(ping), 0);
      chk("rstgap_active", int'(burst_active), 0);
      chk("rstgap_hydro", int'(hydro), 0);
      reset = 1'b0; enable = 1'b0;
      h3_cnt = 0;
      repeat (20) step();
      chk("rstgap_tail", h3_cnt, 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
